// File: rtl/stp_word_deser_pkg.sv
// Shared types and constants for the serial-to-parallel word deserialiser.
package stp_pkg;

  typedef enum logic {
    STP_DIR_LSB = 1'b0,
    STP_DIR_MSB = 1'b1
  } stp_dir_t;

  typedef enum logic {
    STP_EMPTY = 1'b0,
    STP_FULL  = 1'b1
  } stp_hold_t;

  localparam int unsigned DROP_CNT_W = 8;

  // Saturating increment for the dropped-word counter.
  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] one;
    one = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : (v + one);
  endfunction

endpackage

// File: rtl/stp_word_deser_if.sv
// Beat input / word output bus of stp_word_deser.
// drop_count is present only when STP_DROP_CNT_EN is defined.
interface stp_word_deser_if #(
  parameter int unsigned IN_W       = 1,
  parameter int unsigned WORD_BEATS = 16
);
  import stp_pkg::*;

  localparam int unsigned W = IN_W * WORD_BEATS;

  logic            shift_enable;
  logic [IN_W-1:0] serial_in;
  logic            msb_first;
  logic            sync;
  logic            out_ready;
  logic            clear_err;
  logic            out_valid;
  logic [W-1:0]    parallel_out;
  logic            overrun;
`ifdef STP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_count;
`endif

  modport master (
    output shift_enable, serial_in, msb_first, sync, out_ready, clear_err,
`ifdef STP_DROP_CNT_EN
    input  drop_count,
`endif
    input  out_valid, parallel_out, overrun
  );

  modport slave (
    input  shift_enable, serial_in, msb_first, sync, out_ready, clear_err,
`ifdef STP_DROP_CNT_EN
    output drop_count,
`endif
    output out_valid, parallel_out, overrun
  );

endinterface

// File: rtl/stp_word_deser_beat_counter.sv
// Rollover beat counter with synchronous clear, enable and terminal-count flag.
module stp_beat_counter #(
  parameter  int unsigned MAX = 16,
  localparam int unsigned CW  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          zero_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] base_s;

  // Next count: clear first, then a same-cycle enable advances from zero.
  always_comb begin
    base_s  = clr_i ? {CW{1'b0}} : count_q;
    count_d = base_s;
    if (en_i) begin
      if (base_s == LAST) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = base_s + CW'(1);
      end
    end else begin
      count_d = base_s;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {CW{1'b0}});
  assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/stp_word_deser.sv
// Serial-to-parallel word deserialiser with a one-word holding register.
// Optional feature macro: STP_DROP_CNT_EN adds a saturating dropped-word counter.
module stp_word_deser
  import stp_pkg::*;
#(
  parameter int unsigned IN_W       = 1,
  parameter int unsigned WORD_BEATS = 16,
  parameter logic        FILL_BIT   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  stp_word_deser_if.slave bus
);

  localparam int unsigned W  = IN_W * WORD_BEATS;
  localparam int unsigned CW = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
  localparam logic [W-1:0] FILL = {W{FILL_BIT}};

  logic [W-1:0]  sr_q, sr_d, sr_base_s;
  stp_dir_t      dir_q, dir_d, dir_use_s;
  stp_hold_t     hold_q;
  logic [W-1:0]  par_q;
  logic          overrun_q;
  logic [CW-1:0] cnt_s;
  logic          cnt_zero_s, cnt_tc_s;
  logic          first_s, complete_s, drop_s;

  stp_beat_counter #(.MAX(WORD_BEATS)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.sync),
    .en_i    (bus.shift_enable),
    .count_o (cnt_s),
    .zero_o  (cnt_zero_s),
    .tc_o    (cnt_tc_s)
  );

  // A sync collapses the word to beat 0, so the same-cycle beat starts fresh.
  assign first_s    = bus.sync | cnt_zero_s;
  assign complete_s = bus.shift_enable & ~bus.sync & cnt_tc_s;
  assign drop_s     = complete_s & (hold_q == STP_FULL) & ~bus.out_ready;

  // Shift register and latched direction next-state.
  always_comb begin
    sr_base_s = bus.sync ? FILL : sr_q;
    dir_use_s = first_s ? stp_dir_t'(bus.msb_first) : dir_q;
    sr_d      = sr_base_s;
    dir_d     = dir_q;
    if (bus.shift_enable) begin
      dir_d = dir_use_s;
      if (dir_use_s == STP_DIR_MSB) begin
        sr_d = {sr_base_s[W-IN_W-1:0], bus.serial_in};
      end else begin
        sr_d = {bus.serial_in, sr_base_s[W-1:IN_W]};
      end
    end else begin
      sr_d  = sr_base_s;
      dir_d = dir_q;
    end
  end

  // Shift register and direction state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= FILL;
      dir_q <= STP_DIR_MSB;
    end else begin
      sr_q  <= sr_d;
      dir_q <= dir_d;
    end
  end

  // Holding-register FSM with registered word and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= STP_EMPTY;
      par_q     <= FILL;
      overrun_q <= 1'b0;
    end else begin
      case (hold_q)
        STP_EMPTY: begin
          if (complete_s) begin
            hold_q <= STP_FULL;
            par_q  <= sr_d;
          end
        end
        STP_FULL: begin
          if (complete_s && bus.out_ready) begin
            par_q <= sr_d;
          end else if (!complete_s && bus.out_ready) begin
            hold_q <= STP_EMPTY;
          end
        end
        default: begin
          hold_q <= STP_EMPTY;
        end
      endcase
      if (drop_s) begin
        overrun_q <= 1'b1;
      end else if (bus.clear_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef STP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Dropped-word counter; a drop beside a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
    end else if (drop_s) begin
      drop_cnt_q <= bus.clear_err ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : drop_sat_inc(drop_cnt_q);
    end else if (bus.clear_err) begin
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.out_valid    = (hold_q == STP_FULL);
  assign bus.parallel_out = par_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/stp_word_deser.md
# stp_word_deser

Parametrised serial-to-parallel word deserialiser for the FFT sample input path. It accepts IN_W-bit beats, assembles WORD_BEATS beats into one word with per-word shift direction, and presents completed words on a valid/ready interface through one holding register. Overruns are flagged, and a sync input discards partial words. It sits between the serial sample front end and the FFT input buffer.

## Interface
- IN_W, 1: bits per input beat.
- WORD_BEATS, 16: beats per word; must be ≥ 2.
- FILL_BIT, 1'b1: value loaded into every shift-register and output bit at reset and on sync.
- Derived W = IN_W*WORD_BEATS: output word width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- shift_enable  in  1  beat strobe; serial_in is valid this cycle.
- serial_in  in  IN_W  beat data.
- msb_first  in  1  direction; sampled only on beat 0 of each word.
- sync  in  1  discard the partial word; restart at beat 0.
- out_ready  in  1  consumer accepts the word this cycle.
- clear_err  in  1  clears overrun (and drop_count when compiled in).
- out_valid  out  1  holding register holds an unconsumed word.
- parallel_out  out  W  completed word; stable while out_valid=1 and out_ready=0.
- overrun  out  1  sticky; a completed word was dropped.

## Operation
- Reset values:
  - sr, parallel_out = {W{FILL_BIT}}
  - beat count = 0, dir_q = MSB
  - out_valid = 0, overrun = 0
- Beat accept (shift_enable=1):
  - Direction used: msb_first if count==0, else dir_q. dir_q <= msb_first when count==0.
  - MSB-first: sr <= {sr[W-IN_W-1:0], serial_in}.
  - LSB-first: sr <= {serial_in, sr[W-1:IN_W]}.
  - count increments, wrapping WORD_BEATS-1 → 0.
- Word complete (beat accepted with count==WORD_BEATS-1):
  - The post-shift sr value is the word.
  - If the holding register is free (out_valid=0, or out_ready=1 this cycle): parallel_out <= word, out_valid <= 1.
  - Otherwise the word is dropped and overrun <= 1. The held word is kept.
- Handshake:
  - Holding states: EMPTY and FULL.
  - Transfer occurs when out_valid & out_ready.
  - FULL→EMPTY on a transfer with no new word completing that cycle.
  - Transfer and completion in the same cycle: stays FULL with the new word.
- sync:
  - count <= 0 and sr <= fill.
  - If shift_enable is also high, sync wins first, and the same-cycle beat is taken as beat 0 of a new word (direction from msb_first).
  - sync never affects the holding register or out_valid.
- clear_err:
  - overrun <= 0.
  - If a drop occurs in the same cycle, the drop wins and overrun stays 1.
- shift_enable=0: no state change other than the handshake.

## Timing
- Final beat at edge k → out_valid=1 and parallel_out valid after edge k. Latency is 1 cycle from the final beat strobe.
- Back-to-back operation at one beat per cycle is sustained with out_ready held high; there are no bubbles.
- out_ready is used only when out_valid=1. There is no combinational path from serial_in to any output.
- Reset mid-word: all state returns to reset values asynchronously. The partial word is lost, and the first beat after release is beat 0.

## Configuration
- STP_DROP_CNT_EN defined:
  - Adds output drop_count [DROP_CNT_W-1:0].
  - Increments per dropped word and saturates at all-ones.
  - Cleared by clear_err; a same-cycle drop makes it 1, not 0.
  - Resets to 0.
- STP_DROP_CNT_EN undefined: the port and counter are absent. overrun behaviour is unchanged.

## Structure
- Package stp_pkg:
  - enum stp_dir_t {STP_DIR_LSB, STP_DIR_MSB}
  - enum stp_hold_t {STP_EMPTY, STP_FULL}
  - localparam DROP_CNT_W = 8
- Sub-module stp_beat_counter:
  - Parametrised rollover counter with sync clear, enable and a terminal-count output.
  - Instantiated once for the beat count.

## Test plan
- IN_W=4, WORD_BEATS=4, msb_first=1, out_ready=1; beats A,B,C,D → parallel_out=16'hABCD, out_valid high for exactly 1 cycle after beat D.
- Same beats, msb_first=0 on beat 0, then toggled to 1 mid-word → 16'hDCBA (direction latched at beat 0).
- out_ready=0; two words 0x1234 then 0x5678 → parallel_out holds 0x1234 and overrun=1. With STP_DROP_CNT_EN, drop_count=1. Raising out_ready then transfers 0x1234.
- Beats 1,2, then sync together with beat 9, then 8,7,6 → 16'h9876; no overrun.
- Beats A,B, then rst pulse, then 3,4,5,6 → out_valid=0 during reset, next word 16'h3456.
- Continuous beats at 1 per cycle with out_ready=1 for 3 words → 3 out_valid pulses, 4 cycles apart, and no overrun.
